// File: rtl/sha3_pkg.sv
// Shared constants, state encoding and beat helpers for the SHA3-512 unpadder.
// Byte order throughout is MSB-first: byte 0 of a word is bits [31:24].
package sha3_pkg;

  localparam int SHA3_RATE_WORDS = 18;
  localparam int SHA3_RATE_BYTES = 72;

  localparam logic [7:0] SHA3_PAD_FIRST = 8'h06;
  localparam logic [7:0] SHA3_PAD_LAST  = 8'h80;
  localparam logic [7:0] SHA3_PAD_BOTH  = 8'h86;

  typedef enum logic [1:0] {
    FILL,
    SCAN,
    DRAIN
  } unpad_state_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [2:0]  bytes;
  } unpad_beat_t;

  // Keeps the leading n message bytes of a word; n >= 4 keeps all of it.
  function automatic logic [31:0] keep_mask(input logic [2:0] n);
    case (n)
      3'd0:    keep_mask = 32'h0000_0000;
      3'd1:    keep_mask = 32'hFF00_0000;
      3'd2:    keep_mask = 32'hFFFF_0000;
      3'd3:    keep_mask = 32'hFFFF_FF00;
      default: keep_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/sha3_word_pad_find.sv
// Locates the last (highest message index) nonzero byte of one word.
// Byte 0 is bits [31:24], so byte 3 (bits [7:0]) has the highest index.
module sha3_word_pad_find
  import sha3_pkg::*;
(
  input  logic [31:0] word,
  output logic [1:0]  idx,
  output logic        found,
  output logic [7:0]  value
);

  // Later iterations override earlier ones, so the highest index wins.
  always_comb begin
    idx   = 2'd0;
    found = 1'b0;
    value = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (word[31-8*i -: 8] != 8'h00) begin
        idx   = 2'(i);
        found = 1'b1;
        value = word[31-8*i -: 8];
      end
    end
  end

endmodule

// File: rtl/sha3_unpadder.sv
// Removes SHA3-512 padding from 18-word rate blocks and re-emits the message
// words, with a byte count on the last word of the final block.
module sha3_unpadder
  import sha3_pkg::*;
#(
  parameter int RATE_WORDS = SHA3_RATE_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [2:0]  out_bytes,
  output logic        pad_err
);

  localparam int IDX_W = $clog2(RATE_WORDS + 1);
  localparam int LEN_W = $clog2(4 * RATE_WORDS + 1);
  localparam int LR_W  = LEN_W + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_WORDS - 1);
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(4 * RATE_WORDS);
  localparam logic [LEN_W-1:0] BOTH_LEN = LEN_W'(4 * RATE_WORDS - 1);

  unpad_state_t state, state_d;

  logic [31:0]      blk_buf [RATE_WORDS];
  logic [IDX_W-1:0] wr_idx, wr_idx_d;
  logic [IDX_W-1:0] scan_idx, scan_idx_d;
  logic [IDX_W-1:0] rd_idx, rd_idx_d;
  logic [LEN_W-1:0] msg_len, msg_len_d;
  logic             is_final, is_final_d;

  logic [31:0] out_d;
  logic        out_valid_d;
  logic        out_last_d;
  logic [2:0]  out_bytes_d;
  logic        pad_err_d;

  logic             accept;
  logic [7:0]       last_byte;
  logic [31:0]      scan_word;
  logic [1:0]       find_idx;
  logic             find_found;
  logic [7:0]       find_value;
  logic             scan_ok;
  logic             scan_err;
  logic             load;
  logic [LEN_W-1:0] found_len;
  unpad_beat_t      beat;

  // An empty message still produces one (zero-byte) beat.
  function automatic logic [IDX_W-1:0] beat_count(input logic [LEN_W-1:0] len);
    logic [LR_W-1:0] rounded;
    rounded = {1'b0, len} + LR_W'(3);
    return (len == '0) ? IDX_W'(1) : IDX_W'(rounded >> 2);
  endfunction

  function automatic unpad_beat_t make_beat(
    input logic [31:0]      word,
    input logic [IDX_W-1:0] idx,
    input logic [LEN_W-1:0] len,
    input logic             fin
  );
    unpad_beat_t      b;
    logic [LEN_W-1:0] rem;
    rem     = len - LEN_W'({idx, 2'b00});
    b.last  = fin && (idx == beat_count(len) - 1'b1);
    b.bytes = b.last ? rem[2:0] : 3'd4;
    b.data  = b.last ? (word & keep_mask(rem[2:0])) : word;
    return b;
  endfunction

  assign in_ready  = (state == FILL);
  assign accept    = in_valid && in_ready;
  assign last_byte = blk_buf[LAST_IDX][7:0];

  // The final pad byte is treated as zero while hunting for the 0x06 marker.
  always_comb begin
    scan_word = blk_buf[scan_idx];
    if (scan_idx == LAST_IDX) scan_word[7:0] = 8'h00;
  end

  sha3_word_pad_find u_find (
    .word  (scan_word),
    .idx   (find_idx),
    .found (find_found),
    .value (find_value)
  );

  always_ff @(posedge clk) begin
    if (accept) blk_buf[wr_idx] <= in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= state_d;
  end

  always_comb begin
    state_d     = state;
    wr_idx_d    = wr_idx;
    scan_idx_d  = scan_idx;
    rd_idx_d    = rd_idx;
    msg_len_d   = msg_len;
    is_final_d  = is_final;
    out_d       = out;
    out_valid_d = out_valid;
    out_last_d  = out_last;
    out_bytes_d = out_bytes;
    pad_err_d   = 1'b0;
    scan_ok     = 1'b0;
    scan_err    = 1'b0;
    load        = 1'b0;
    found_len   = '0;
    beat        = '0;

    case (state)
      FILL: begin
        if (accept) begin
          if (wr_idx == LAST_IDX) begin
            wr_idx_d   = '0;
            is_final_d = in_last;
            if (in_last) begin
              state_d    = SCAN;
              scan_idx_d = LAST_IDX;
            end else begin
              state_d   = DRAIN;
              msg_len_d = FULL_LEN;
              beat      = make_beat(blk_buf[0], '0, FULL_LEN, 1'b0);
              load      = 1'b1;
              rd_idx_d  = IDX_W'(1);
            end
          end else if (in_last) begin
            pad_err_d = 1'b1;
            wr_idx_d  = '0;
          end else begin
            wr_idx_d = wr_idx + 1'b1;
          end
        end
      end

      SCAN: begin
        if (scan_idx == LAST_IDX && last_byte == SHA3_PAD_BOTH) begin
          found_len = BOTH_LEN;
          scan_ok   = 1'b1;
        end else if (scan_idx == LAST_IDX && last_byte != SHA3_PAD_LAST) begin
          scan_err = 1'b1;
        end else if (find_found) begin
          if (find_value == SHA3_PAD_FIRST) begin
            found_len = LEN_W'({scan_idx, 2'b00}) + LEN_W'(find_idx);
            scan_ok   = 1'b1;
          end else begin
            scan_err = 1'b1;
          end
        end else if (scan_idx == '0) begin
          scan_err = 1'b1;
        end else begin
          scan_idx_d = scan_idx - 1'b1;
        end

        if (scan_ok) begin
          state_d   = DRAIN;
          msg_len_d = found_len;
          beat      = make_beat(blk_buf[0], '0, found_len, 1'b1);
          load      = 1'b1;
          rd_idx_d  = IDX_W'(1);
        end
        if (scan_err) begin
          state_d   = FILL;
          wr_idx_d  = '0;
          pad_err_d = 1'b1;
        end
      end

      DRAIN: begin
        // Beat 0 was loaded on entry; each accepted beat pulls in the next one.
        if (out_valid && out_ready) begin
          if (rd_idx < beat_count(msg_len)) begin
            beat     = make_beat(blk_buf[rd_idx], rd_idx, msg_len, is_final);
            load     = 1'b1;
            rd_idx_d = rd_idx + 1'b1;
          end else begin
            state_d     = FILL;
            wr_idx_d    = '0;
            rd_idx_d    = '0;
            out_valid_d = 1'b0;
            out_d       = '0;
            out_last_d  = 1'b0;
            out_bytes_d = '0;
          end
        end
      end

      default: state_d = FILL;
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      out_d       = beat.data;
      out_last_d  = beat.last;
      out_bytes_d = beat.bytes;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_idx    <= '0;
      scan_idx  <= '0;
      rd_idx    <= '0;
      msg_len   <= '0;
      is_final  <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_bytes <= '0;
      pad_err   <= 1'b0;
    end else begin
      wr_idx    <= wr_idx_d;
      scan_idx  <= scan_idx_d;
      rd_idx    <= rd_idx_d;
      msg_len   <= msg_len_d;
      is_final  <= is_final_d;
      out       <= out_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
      out_bytes <= out_bytes_d;
      pad_err   <= pad_err_d;
    end
  end

endmodule

// File: tb/tb_sha3_unpadder.sv
// Scoreboard bench for sha3_unpadder: a byte-level reference model predicts
// beats and pad errors, and a monitor compares whatever the DUT emits.
module tb_sha3_unpadder;

  localparam int CYCLE_LIMIT = 2000;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [2:0]  bytes;
  } exp_beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_word = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [31:0] out_word;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic [2:0]  out_bytes;
  logic        pad_err;

  int          checks = 0;
  int          errors = 0;
  exp_beat_t   exp_q[$];
  int          exp_err = 0;
  int          ready_mode = 0;

  logic [31:0] blk [18];
  logic [7:0]  pb  [72];

  sha3_unpadder dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in_word),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out       (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_bytes (out_bytes),
    .pad_err   (pad_err)
  );

  initial forever #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic abort_run(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound of %0d cycles expired", name, CYCLE_LIMIT);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Reference model: works on the 72 padded bytes, not on words or states.
  task automatic expect_block(input bit fin, input int last_at);
    logic [7:0]  b [72];
    int          len;
    bit          bad;
    int          nbeats;
    int          cnt;
    exp_beat_t   e;
    if (fin && last_at != 17) begin
      exp_err++;
      return;
    end
    for (int i = 0; i < 72; i++) b[i] = blk[i/4][31-8*(i%4) -: 8];
    bad = 1'b0;
    len = 72;
    if (fin) begin
      if (b[71] == 8'h86) len = 71;
      else if (b[71] != 8'h80) bad = 1'b1;
      else begin
        b[71] = 8'h00;
        len = -1;
        for (int i = 70; i >= 0; i--) begin
          if (b[i] != 8'h00) begin
            len = i;
            break;
          end
        end
        if (len < 0) bad = 1'b1;
        else if (b[len] != 8'h06) bad = 1'b1;
      end
    end
    if (bad) begin
      exp_err++;
      return;
    end
    nbeats = (len == 0) ? 1 : (len + 3) / 4;
    for (int k = 0; k < nbeats; k++) begin
      e.last  = fin && (k == nbeats - 1);
      cnt     = e.last ? len - 4*k : 4;
      e.bytes = 3'(cnt);
      e.data  = '0;
      for (int j = 0; j < cnt; j++) e.data[31-8*j -: 8] = b[4*k + j];
      exp_q.push_back(e);
    end
  endtask

  task automatic apply_stimulus(input bit fin, input int last_at);
    int waited;
    for (int i = 0; i <= last_at; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_word  = blk[i];
      in_valid = 1'b1;
      in_last  = fin && (i == last_at);
      waited   = 0;
      while (!in_ready) begin
        if (waited == CYCLE_LIMIT) abort_run("in_ready_wait");
        @(posedge clk);
        #1;
        waited++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_block(input bit fin, input int last_at);
    expect_block(fin, last_at);
    apply_stimulus(fin, last_at);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 || exp_err != 0) begin
      if (n == CYCLE_LIMIT) abort_run("drain_wait");
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pack_block();
    for (int w = 0; w < 18; w++) blk[w] = {pb[4*w], pb[4*w+1], pb[4*w+2], pb[4*w+3]};
  endtask

  task automatic build_final(input int len);
    for (int i = 0; i < 72; i++) pb[i] = (i < len) ? 8'($urandom) : 8'h00;
    if (len == 71) pb[71] = 8'h86;
    else begin
      pb[len] = 8'h06;
      pb[71]  = 8'h80;
    end
    pack_block();
  endtask

  // Monitor: pops the scoreboard on each accepted beat and checks hold stability.
  logic        hold_prev = 1'b0;
  logic [31:0] hold_out;
  logic        hold_last;
  logic [2:0]  hold_bytes;

  always @(negedge clk) begin
    exp_beat_t e;
    if (!reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check_output("hold_out", out_word, hold_out);
        check_output("hold_last", {31'b0, out_last}, {31'b0, hold_last});
        check_output("hold_bytes", {29'b0, out_bytes}, {29'b0, hold_bytes});
      end
      hold_prev  = out_valid && !out_ready;
      hold_out   = out_word;
      hold_last  = out_last;
      hold_bytes = out_bytes;
      if (out_valid) check_output("in_ready_while_out", {31'b0, in_ready}, 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL beat_unexpected: got 0x%08h last=%0d bytes=%0d, expected no beat",
                   out_word, out_last, out_bytes);
        end else begin
          e = exp_q.pop_front();
          check_output("beat_data", out_word, e.data);
          check_output("beat_last", {31'b0, out_last}, {31'b0, e.last});
          check_output("beat_bytes", {29'b0, out_bytes}, {29'b0, e.bytes});
        end
      end
      if (pad_err) begin
        checks++;
        if (exp_err > 0) exp_err--;
        else begin
          errors++;
          $display("[TB] FAIL pad_err_unexpected: got 1, expected 0");
        end
      end
    end
  end

  initial begin
    int kind;
    int len;

    $display("[TB] reset and idle checks");
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check_output("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check_output("reset_out", out_word, 32'd0);
    check_output("reset_out_last", {31'b0, out_last}, 32'd0);
    check_output("reset_out_bytes", {29'b0, out_bytes}, 32'd0);
    check_output("reset_pad_err", {31'b0, pad_err}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    $display("[TB] aligned non-final block");
    for (int i = 0; i < 18; i++) blk[i] = 32'(i + 1);
    run_block(1'b0, 17);
    wait_drain();

    $display("[TB] five-byte final block");
    for (int i = 0; i < 18; i++) blk[i] = '0;
    blk[0]  = 32'h1122_3344;
    blk[1]  = 32'h5506_0000;
    blk[17] = 32'h0000_0080;
    run_block(1'b1, 17);
    wait_drain();

    $display("[TB] 71-byte final block with combined pad byte");
    for (int i = 0; i < 17; i++) blk[i] = $urandom;
    blk[17] = 32'hAABB_CC86;
    run_block(1'b1, 17);
    @(negedge clk);
    check_output("scan_cycle_no_out", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    check_output("scan_one_cycle", {31'b0, out_valid}, 32'd1);
    wait_drain();

    $display("[TB] empty message");
    for (int i = 0; i < 18; i++) blk[i] = '0;
    blk[0]  = 32'h0600_0000;
    blk[17] = 32'h0000_0080;
    run_block(1'b1, 17);
    wait_drain();

    $display("[TB] bad final pad byte then recovery");
    blk[17] = 32'h0000_0081;
    run_block(1'b1, 17);
    wait_drain();
    build_final(9);
    run_block(1'b1, 17);
    wait_drain();

    $display("[TB] early in_last then aligned block");
    for (int i = 0; i < 18; i++) blk[i] = $urandom;
    run_block(1'b1, 5);
    wait_drain();
    for (int i = 0; i < 18; i++) blk[i] = $urandom;
    run_block(1'b0, 17);
    wait_drain();

    $display("[TB] backpressure mid-drain");
    for (int i = 0; i < 18; i++) blk[i] = $urandom;
    run_block(1'b0, 17);
    repeat (4) @(negedge clk);
    ready_mode = 2;
    repeat (3) @(posedge clk);
    ready_mode = 0;
    wait_drain();

    $display("[TB] reset during drain");
    ready_mode = 2;
    @(posedge clk);
    #1;
    for (int i = 0; i < 18; i++) blk[i] = $urandom;
    run_block(1'b0, 17);
    @(negedge clk);
    check_output("drain_before_reset", {31'b0, out_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_output("reset_drops_out_valid", {31'b0, out_valid}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    ready_mode = 0;
    check_output("post_reset_in_ready", {31'b0, in_ready}, 32'd1);
    check_output("post_reset_out_valid", {31'b0, out_valid}, 32'd0);
    build_final(23);
    run_block(1'b1, 17);
    wait_drain();

    $display("[TB] randomized blocks");
    ready_mode = 1;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 5);
      len  = $urandom_range(0, 71);
      case (kind)
        0: begin
          for (int i = 0; i < 18; i++) blk[i] = $urandom;
          run_block(1'b0, 17);
        end
        1, 2: begin
          build_final(len);
          run_block(1'b1, 17);
        end
        3: begin
          build_final(len);
          pb[71] = 8'($urandom);
          pack_block();
          run_block(1'b1, 17);
        end
        4: begin
          build_final(len);
          pb[len] = 8'($urandom_range(1, 255));
          pack_block();
          run_block(1'b1, 17);
        end
        default: begin
          for (int i = 0; i < 18; i++) blk[i] = $urandom;
          run_block(1'b1, $urandom_range(0, 16));
        end
      endcase
    end
    wait_drain();
    ready_mode = 0;
    repeat (3) @(negedge clk);
    check_output("final_in_ready", {31'b0, in_ready}, 32'd1);
    check_output("final_out_valid", {31'b0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
